axis_pkt_pacer: RTL and testbench

- Synthesizable AXI4-Stream packet pacer that sits between a packet source (replay buffer, DMA, generator) and a MAC or DUT.
- Gates the start of each packet to enforce inter-packet spacing in one of three modes: back-to-back, fixed IFG, or timestamp-derived.
- Data path is a zero-latency pass-through; only packet starts are held back.
- Supersedes fixed-width, simulation-only replay pacing: width is parametrised, the mode is selectable at run time, and the block adds boundary-only pause and error/statistics outputs.

---
 rtl/axis_pkt_pacer.sv | 105 ++++++++++
 tb/tb_axis_pkt_pacer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_pacer.sv
// axis_pkt_pacer: AXI4-Stream pass-through that holds back packet starts to enforce
// back-to-back, fixed-IFG or timestamp-derived inter-packet spacing.
module axis_pkt_pacer #(
    parameter int AXIS_WIDTH = 512,
    parameter int TS_WIDTH   = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AXIS_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [TS_WIDTH-1:0]     s_axis_ts,
    output logic [AXIS_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic [1:0]              cfg_mode,
    input  logic [CNT_WIDTH-1:0]    cfg_ifg,
    input  logic [31:0]             cfg_cyc_per_ns,
    input  logic                    pause,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic                    ts_err
);
    typedef enum logic [1:0] {SOP_WAIT, CALC, GATE, PASS} state_t;
    state_t state, state_nxt;
    logic [1:0]          mode;
    logic                gate_open, hs, sop_hs, eop_hs, ifg_met, ts_met, neg, first_pkt;
    logic [CNT_WIDTH-1:0] idle_cnt, sop_cnt, target, target_calc;
    logic [TS_WIDTH-1:0] ts_lat, prev_ts;
    logic [TS_WIDTH:0]   delta_full;
    logic [31:0]         delta_c;
    logic [63:0]         prod;
    logic [64:0]         rnd;
    logic [48:0]         quo;
    assign mode = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;
    assign hs = s_axis_tvalid && s_axis_tready;
    assign sop_hs = hs && (state == SOP_WAIT || state == GATE);
    assign eop_hs = hs && s_axis_tlast;
    assign ifg_met = (mode == 2'd1) ? (idle_cnt >= cfg_ifg) : 1'b1;
    // sop_cnt reads k-1 in the k-th cycle after an SOP, so a target of T releases exactly T cycles later
    assign ts_met = (target == '0) || (sop_cnt >= target - 1'b1);
    assign delta_full = {1'b0, ts_lat} - {1'b0, prev_ts};
    assign neg = delta_full[TS_WIDTH];
    assign delta_c = (|delta_full[TS_WIDTH-1:32]) ? 32'hFFFF_FFFF : delta_full[31:0];
    assign prod = {32'd0, delta_c} * {32'd0, cfg_cyc_per_ns};
    assign rnd = {1'b0, prod} + 65'h0_FFFF;
    assign quo = rnd[64:16];
    assign target_calc = (first_pkt || neg) ? '0 :
                         (|quo[48:CNT_WIDTH]) ? '1 : quo[CNT_WIDTH-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SOP_WAIT;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            SOP_WAIT: state_nxt = (mode == 2'd2 && s_axis_tvalid) ? CALC :
                                  (hs && !s_axis_tlast) ? PASS : SOP_WAIT;
            CALC:     state_nxt = GATE;
            GATE:     state_nxt = hs ? (s_axis_tlast ? SOP_WAIT : PASS) : GATE;
            PASS:     state_nxt = eop_hs ? SOP_WAIT : PASS;
            default:  state_nxt = SOP_WAIT;
        endcase
    end
    always_comb begin
        gate_open = !rst_n ? 1'b0 :
                    (state == PASS) ? 1'b1 :
                    (state == SOP_WAIT) ? (!pause && mode != 2'd2 && ifg_met) :
                    (state == GATE) ? (!pause && ts_met) : 1'b0;
        busy = (state == PASS);
        s_axis_tready = m_axis_tready && gate_open;
        m_axis_tvalid = s_axis_tvalid && gate_open;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
            ts_err    <= 1'b0;
            first_pkt <= 1'b1;
            idle_cnt  <= '0;
            sop_cnt   <= '0;
            target    <= '0;
            ts_lat    <= '0;
            prev_ts   <= '0;
        end else begin
            if (eop_hs) pkt_count <= pkt_count + 1'b1;
            idle_cnt <= eop_hs ? '0 : (&idle_cnt) ? idle_cnt : idle_cnt + 1'b1;
            sop_cnt  <= sop_hs ? '0 : (&sop_cnt) ? sop_cnt : sop_cnt + 1'b1;
            if (sop_hs) first_pkt <= 1'b0;
            if (state == SOP_WAIT && state_nxt == CALC) ts_lat <= s_axis_ts;
            if (state == CALC) begin
                target  <= target_calc;
                prev_ts <= ts_lat;
                if (!first_pkt && neg) ts_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_pkt_pacer.sv
// tb_axis_pkt_pacer: directed scoreboard bench for axis_pkt_pacer; the driver queues
// expected beats and an independent monitor checks every output handshake.
module tb_axis_pkt_pacer;
    localparam int W = 32;
    logic        clk = 0, rst_n = 0;
    logic [W-1:0] s_tdata = '0, m_tdata;
    logic [3:0]  s_tkeep = '0, m_tkeep;
    logic        s_tlast = 0, s_tvalid = 0, s_tready, m_tlast, m_tvalid, m_tready = 1;
    logic [63:0] s_ts = '0;
    logic [1:0]  cfg_mode = 0;
    logic [31:0] cfg_ifg = 0, cfg_cyc = 0, pkt_count;
    logic        pause = 0, busy, ts_err;
    logic        rnd_rdy = 0, gap_chk = 0, in_pkt = 0, have_eop = 0;
    int          total = 0, bad = 0, cyc = 0, last_eop = 0, ifg_chk = 0;
    int          hs_cycs[$], sop_cycs[$];
    logic [36:0] exp_q[$];

    axis_pkt_pacer #(.AXIS_WIDTH(W), .TS_WIDTH(64), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_ts(s_ts),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .cfg_mode(cfg_mode), .cfg_ifg(cfg_ifg), .cfg_cyc_per_ns(cfg_cyc),
        .pause(pause), .busy(busy), .pkt_count(pkt_count), .ts_err(ts_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) m_tready <= rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and tracks packet boundaries.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_pkt = 0;
            have_eop = 0;
        end else if (m_tvalid && m_tready) begin
            hs_cycs.push_back(cyc);
            if (!in_pkt) begin
                sop_cycs.push_back(cyc);
                if (gap_chk && have_eop) chk("ifg_gap_ok", 64'(cyc - last_eop - 1 >= ifg_chk), 1);
            end
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else chk("beat", {27'd0, m_tlast, m_tkeep, m_tdata}, {27'd0, exp_q.pop_front()});
            in_pkt = !m_tlast;
            if (m_tlast) begin
                last_eop = cyc;
                have_eop = 1;
            end
        end
    end

    task automatic wait_hs();
        int n = 0;
        @(negedge clk);
        while (!s_tready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) chk("hs_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input logic [63:0] ts, input int pause_beat);
        for (int b = 0; b < len; b++) begin
            s_tdata = $urandom;
            s_tkeep = 4'($urandom);
            s_tlast = (b == len - 1);
            s_tvalid = 1;
            s_ts = ts;
            if (b == pause_beat) pause = 1;
            exp_q.push_back({s_tlast, s_tkeep, s_tdata});
            wait_hs();
        end
    endtask

    task automatic go_idle(input int n);
        s_tvalid = 0;
        s_tlast = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0;
        s_tvalid = 1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ts_err", ts_err, 0);
        s_tvalid = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        hs_cycs.delete();
        sop_cycs.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Mode 0: three 2-beat packets stream back-to-back
        cfg_mode = 0;
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(2, 0, -1);
        go_idle(3);
        chk("m0_beats", hs_cycs.size(), 6);
        chk("m0_consecutive", hs_cycs[5] - hs_cycs[0], 5);
        chk("m0_pkt_count", pkt_count, 3);

        // Mode 1: exactly cfg_ifg idle cycles between EOP and next SOP
        cfg_mode = 1;
        cfg_ifg = 6;
        do_reset();
        send_pkt(1, 0, -1);
        send_pkt(1, 0, -1);
        go_idle(3);
        chk("m1_gap", sop_cycs[1] - sop_cycs[0] - 1, 6);
        chk("m1_pkt_count", pkt_count, 2);

        // Mode 2: 100 ns at 0.3125 cycles/ns -> ceil(31.25) = 32 cycles start-to-start
        cfg_mode = 2;
        cfg_cyc = 32'h0000_5000;
        do_reset();
        send_pkt(1, 0, -1);
        send_pkt(1, 100, -1);
        go_idle(3);
        chk("m2_spacing", sop_cycs[1] - sop_cycs[0], 32);
        chk("m2_ts_err", ts_err, 0);

        // Mode 2 backwards timestamp: release right after CALC, sticky error
        do_reset();
        send_pkt(1, 1000, -1);
        send_pkt(1, 500, -1);
        go_idle(2);
        chk("m2_neg_spacing", sop_cycs[1] - sop_cycs[0], 3);
        chk("m2_neg_ts_err", ts_err, 1);
        send_pkt(1, 2000, -1);
        go_idle(3);
        chk("m2_round_up", sop_cycs[2] - sop_cycs[1], 469);
        chk("m2_ts_err_sticky", ts_err, 1);

        // Pause mid-packet only takes effect at the next boundary
        cfg_mode = 0;
        do_reset();
        send_pkt(4, 0, 1);
        @(negedge clk);
        chk("pause_beats", hs_cycs.size(), 4);
        chk("pause_busy_after_eop", busy, 0);
        fork
            send_pkt(1, 0, -1);
            begin
                repeat (10) @(negedge clk);
                chk("pause_hold", hs_cycs.size(), 4);
                chk("pause_busy_held", busy, 0);
                chk("pause_tvalid_held", m_tvalid, 0);
                @(posedge clk);
                #1;
                pause = 0;
            end
        join
        go_idle(3);
        chk("pause_release", hs_cycs.size(), 5);
        chk("pause_pkt_count", pkt_count, 2);

        // Random backpressure, mode 1 ifg=3, 100 packets of 1..20 beats
        cfg_mode = 1;
        cfg_ifg = 3;
        do_reset();
        ifg_chk = 3;
        gap_chk = 1;
        rnd_rdy = 1;
        for (int p = 0; p < 100; p++) send_pkt($urandom_range(1, 20), 0, -1);
        go_idle(2);
        rnd_rdy = 0;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
        gap_chk = 0;
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_pkt_count", pkt_count, 100);
        chk("rand_sops", sop_cycs.size(), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
